multi_colour_bbox_tracker: RTL and testbench
============================================

Name: multi_colour_bbox_tracker

Overview:
Parametrised successor to the single-colour bounding-box tracker. It sits beside the video pipeline after the HSV classifier and receives a per-pixel class index. For each of N_COLOURS colour channels it tracks the bounding box and pixel count over one frame. Every MSG_INTERVAL frames it emits a framed message stream (valid/ready) to the CPU-side message FIFO; channels with too few pixels are suppressed.

Parameters:
IMAGE_W, 640, pixels per line
IMAGE_H, 480, lines per frame
N_COLOURS, 4, number of tracked colour channels (1..15)
CLASS_W, 4, width of class index; 0 = unclassified, k+1 = channel k
COORD_W, 11, coordinate width (<=16)
CNT_W, 20, per-channel pixel counter width (saturating)
MSG_INTERVAL, 6, frames between reports (>=1)
MIN_PIXELS, 16, minimum count for a channel to be reported

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
pix_valid  in  1  beat qualifier from stream input register
pix_sop  in  1  start of packet (descriptor beat, not a pixel)
pix_eop  in  1  end of packet (last pixel beat)
pix_video  in  1  on sop beat: 1 = video packet, 0 = control packet
pix_class  in  CLASS_W  class index of current pixel
msg_data  out  32  message word
msg_valid  out  1  msg_data valid
msg_ready  in  1  sink accepts word
busy  out  1  emitter not IDLE
frame_done  out  1  one-cycle pulse on accepted video eop
msg_dropped  out  1  one-cycle pulse when a report is due but the emitter is busy

Behaviour:
- Reset (async): x, y, accumulators, snapshots, frame_seq = 0; frame_cnt = 0; FSM = IDLE; msg_valid, busy, frame_done, msg_dropped = 0; msg_data = 0.
- Beats are counted only when pix_valid = 1.
- sop beat: x = y = 0; video_flag = pix_video. All channels: x_min = IMAGE_W-1, y_min = IMAGE_H-1, x_max = y_max = cnt = 0. A beat with sop and eop both set is treated as sop only.
- Pixel beat (valid, not sop, video_flag = 1):
  - If x == IMAGE_W-1: x = 0, y = y+1. Otherwise x = x+1.
  - If pix_class = k+1 with k < N_COLOURS: update min/max with the current (x, y) and increment cnt[k], saturating at all-ones.
  - Classes 0 and >N_COLOURS are ignored.
- Non-video packets: no coordinate or accumulator update; their eop is ignored.
- Video eop beat (after that pixel's update): snapshot all channels into shadow registers; frame_done pulses next cycle.
  - If frame_cnt == 0: frame_cnt = MSG_INTERVAL-1. If FSM is IDLE, start the emitter and increment frame_seq; otherwise pulse msg_dropped and keep the old emission running.
  - Otherwise: frame_cnt = frame_cnt-1.
- Emitter FSM:
  - States: IDLE, SCAN, HDR, TL, BR, CNT, END.
  - SCAN: ch index starts at 0. If shadow cnt[ch] >= MIN_PIXELS go to HDR, otherwise skip. After the last channel go to END. SCAN spends one cycle per channel.
  - HDR word = {8'h42, 4'h0, ch[3:0], frame_seq[15:0]}.
  - TL word = {zero-pad to 16, x_min, zero-pad to 16, y_min}.
  - BR word = same packing with x_max, y_max.
  - CNT word = zero-extended cnt.
  - After CNT, ch = ch+1, back to SCAN.
  - END word = {8'h45, 8'h4F, 8'h46, 4'h0, reported_count[3:0]}, then IDLE.
- Handshake: a word is transferred when msg_valid & msg_ready. While msg_valid = 1 and msg_ready = 0, msg_data holds stable and the state does not advance. msg_valid is registered; it is 0 in IDLE and SCAN.
- The snapshot used by an emission is never overwritten mid-emission: a snapshot taken while busy is deferred into a pending slot, and live accumulators keep running. At most one pending snapshot is kept; a newer one overwrites the older.
- All channels below threshold: emission is END only, with count 0.

Test Plan:
- Fill 640x480 frame; ch0 pixels at (100,50) and (200,120); MSG_INTERVAL=1, msg_ready=1 -> HDR 0x4200_0001, TL 0x0064_0032, BR 0x00C8_0078, CNT 0x0000_0002 (MIN_PIXELS=2), END 0x454F_4601.
- Two channels above threshold, msg_ready toggling 1/0 every cycle -> words identical to stall-free run, msg_data held stable during each stall, channels emitted in index order.
- MSG_INTERVAL=6, 13 frames -> emissions after frames 1, 7, 13; frame_done pulses 13 times.
- msg_ready held 0 across two report points -> msg_dropped pulses once; first emission completes unchanged after release.
- Control packet (pix_video=0) carrying class=1 data -> no accumulator change, no frame_done.
- Reset asserted mid-BR word -> msg_valid=0 immediately (async); after release, FSM IDLE, frame_seq=0.

Source files
------------

// File: rtl/multi_colour_bbox_tracker.sv
// Per-colour bounding-box and pixel-count tracker over a classified pixel stream.
// Periodically emits a framed valid/ready report of the channels with enough pixels.
module multi_colour_bbox_tracker #(
  parameter int unsigned IMAGE_W      = 640,
  parameter int unsigned IMAGE_H      = 480,
  parameter int unsigned N_COLOURS    = 4,
  parameter int unsigned CLASS_W      = 4,
  parameter int unsigned COORD_W      = 11,
  parameter int unsigned CNT_W        = 20,
  parameter int unsigned MSG_INTERVAL = 6,
  parameter int unsigned MIN_PIXELS   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pix_valid,
  input  logic               pix_sop,
  input  logic               pix_eop,
  input  logic               pix_video,
  input  logic [CLASS_W-1:0] pix_class,
  output logic [31:0]        msg_data,
  output logic               msg_valid,
  input  logic               msg_ready,
  output logic               busy,
  output logic               frame_done,
  output logic               msg_dropped
);

  localparam int unsigned FC_W = (MSG_INTERVAL > 1) ? $clog2(MSG_INTERVAL) : 1;

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_HDR, S_TL, S_BR, S_CNT, S_END} state_e;

  logic [COORD_W-1:0] x_q, y_q;
  logic               video_q;

  logic [COORD_W-1:0] xmin_q [N_COLOURS], xmin_d [N_COLOURS];
  logic [COORD_W-1:0] ymin_q [N_COLOURS], ymin_d [N_COLOURS];
  logic [COORD_W-1:0] xmax_q [N_COLOURS], xmax_d [N_COLOURS];
  logic [COORD_W-1:0] ymax_q [N_COLOURS], ymax_d [N_COLOURS];
  logic [CNT_W-1:0]   cnt_q  [N_COLOURS], cnt_d  [N_COLOURS];

  logic [COORD_W-1:0] sxmin_q [N_COLOURS], symin_q [N_COLOURS];
  logic [COORD_W-1:0] sxmax_q [N_COLOURS], symax_q [N_COLOURS];
  logic [CNT_W-1:0]   scnt_q  [N_COLOURS];

  logic [COORD_W-1:0] pxmin_q [N_COLOURS], pymin_q [N_COLOURS];
  logic [COORD_W-1:0] pxmax_q [N_COLOURS], pymax_q [N_COLOURS];
  logic [CNT_W-1:0]   pcnt_q  [N_COLOURS];
  logic               pend_q;

  logic [FC_W-1:0]    frame_cnt_q;
  logic [15:0]        frame_seq_q;
  state_e             state_q;
  logic [3:0]         ch_q, rep_q;

  logic [COORD_W-1:0] sel_xmin, sel_ymin, sel_xmax, sel_ymax;
  logic [CNT_W-1:0]   sel_cnt;

  logic sop_beat, pix_beat, vid_eop;

  assign sop_beat = pix_valid & pix_sop;
  assign pix_beat = pix_valid & ~pix_sop & video_q;
  assign vid_eop  = pix_beat & pix_eop;
  assign busy     = (state_q != S_IDLE);

  always_comb begin
    for (int unsigned k = 0; k < N_COLOURS; k++) begin
      xmin_d[k] = xmin_q[k];
      ymin_d[k] = ymin_q[k];
      xmax_d[k] = xmax_q[k];
      ymax_d[k] = ymax_q[k];
      cnt_d[k]  = cnt_q[k];
      if (sop_beat) begin
        xmin_d[k] = COORD_W'(IMAGE_W - 1);
        ymin_d[k] = COORD_W'(IMAGE_H - 1);
        xmax_d[k] = '0;
        ymax_d[k] = '0;
        cnt_d[k]  = '0;
      end else if (pix_beat && pix_class == CLASS_W'(k + 1)) begin
        if (x_q < xmin_q[k]) xmin_d[k] = x_q;
        if (y_q < ymin_q[k]) ymin_d[k] = y_q;
        if (x_q > xmax_q[k]) xmax_d[k] = x_q;
        if (y_q > ymax_q[k]) ymax_d[k] = y_q;
        if (cnt_q[k] != '1) cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    sel_xmin = '0;
    sel_ymin = '0;
    sel_xmax = '0;
    sel_ymax = '0;
    sel_cnt  = '0;
    for (int unsigned k = 0; k < N_COLOURS; k++) begin
      if (ch_q == 4'(k)) begin
        sel_xmin = sxmin_q[k];
        sel_ymin = symin_q[k];
        sel_xmax = sxmax_q[k];
        sel_ymax = symax_q[k];
        sel_cnt  = scnt_q[k];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q     <= '0;
      y_q     <= '0;
      video_q <= 1'b0;
      for (int unsigned k = 0; k < N_COLOURS; k++) begin
        xmin_q[k] <= '0;
        ymin_q[k] <= '0;
        xmax_q[k] <= '0;
        ymax_q[k] <= '0;
        cnt_q[k]  <= '0;
      end
    end else begin
      if (sop_beat) begin
        x_q     <= '0;
        y_q     <= '0;
        video_q <= pix_video;
      end else if (pix_beat) begin
        if (x_q == COORD_W'(IMAGE_W - 1)) begin
          x_q <= '0;
          y_q <= y_q + COORD_W'(1);
        end else begin
          x_q <= x_q + COORD_W'(1);
        end
      end
      for (int unsigned k = 0; k < N_COLOURS; k++) begin
        xmin_q[k] <= xmin_d[k];
        ymin_q[k] <= ymin_d[k];
        xmax_q[k] <= xmax_d[k];
        ymax_q[k] <= ymax_d[k];
        cnt_q[k]  <= cnt_d[k];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < N_COLOURS; k++) begin
        sxmin_q[k] <= '0;
        symin_q[k] <= '0;
        sxmax_q[k] <= '0;
        symax_q[k] <= '0;
        scnt_q[k]  <= '0;
        pxmin_q[k] <= '0;
        pymin_q[k] <= '0;
        pxmax_q[k] <= '0;
        pymax_q[k] <= '0;
        pcnt_q[k]  <= '0;
      end
      pend_q      <= 1'b0;
      frame_cnt_q <= '0;
      frame_seq_q <= '0;
      state_q     <= S_IDLE;
      ch_q        <= '0;
      rep_q       <= '0;
      msg_data    <= '0;
      msg_valid   <= 1'b0;
      frame_done  <= 1'b0;
      msg_dropped <= 1'b0;
    end else begin
      frame_done  <= vid_eop;
      msg_dropped <= 1'b0;

      // Shadow is frozen while emitting; late snapshots park in the pending slot.
      if (vid_eop) begin
        for (int unsigned k = 0; k < N_COLOURS; k++) begin
          if (state_q == S_IDLE) begin
            sxmin_q[k] <= xmin_d[k];
            symin_q[k] <= ymin_d[k];
            sxmax_q[k] <= xmax_d[k];
            symax_q[k] <= ymax_d[k];
            scnt_q[k]  <= cnt_d[k];
          end else begin
            pxmin_q[k] <= xmin_d[k];
            pymin_q[k] <= ymin_d[k];
            pxmax_q[k] <= xmax_d[k];
            pymax_q[k] <= ymax_d[k];
            pcnt_q[k]  <= cnt_d[k];
          end
        end
        pend_q <= (state_q != S_IDLE);
      end else if (state_q == S_IDLE && pend_q) begin
        for (int unsigned k = 0; k < N_COLOURS; k++) begin
          sxmin_q[k] <= pxmin_q[k];
          symin_q[k] <= pymin_q[k];
          sxmax_q[k] <= pxmax_q[k];
          symax_q[k] <= pymax_q[k];
          scnt_q[k]  <= pcnt_q[k];
        end
        pend_q <= 1'b0;
      end

      if (vid_eop) begin
        if (frame_cnt_q == '0) begin
          frame_cnt_q <= FC_W'(MSG_INTERVAL - 1);
          if (state_q == S_IDLE) frame_seq_q <= frame_seq_q + 16'(1);
          else                   msg_dropped <= 1'b1;
        end else begin
          frame_cnt_q <= frame_cnt_q - FC_W'(1);
        end
      end

      case (state_q)
        S_IDLE: begin
          if (vid_eop && frame_cnt_q == '0) begin
            state_q <= S_SCAN;
            ch_q    <= '0;
            rep_q   <= '0;
          end
        end
        S_SCAN: begin
          if (ch_q == 4'(N_COLOURS)) begin
            state_q   <= S_END;
            msg_valid <= 1'b1;
            msg_data  <= {8'h45, 8'h4F, 8'h46, 4'h0, rep_q};
          end else if (32'(sel_cnt) >= 32'(MIN_PIXELS)) begin
            state_q   <= S_HDR;
            msg_valid <= 1'b1;
            msg_data  <= {8'h42, 4'h0, ch_q, frame_seq_q};
          end else begin
            ch_q <= ch_q + 4'd1;
          end
        end
        S_HDR: if (msg_ready) begin
          state_q  <= S_TL;
          msg_data <= {16'(sel_xmin), 16'(sel_ymin)};
        end
        S_TL: if (msg_ready) begin
          state_q  <= S_BR;
          msg_data <= {16'(sel_xmax), 16'(sel_ymax)};
        end
        S_BR: if (msg_ready) begin
          state_q  <= S_CNT;
          msg_data <= 32'(sel_cnt);
        end
        S_CNT: if (msg_ready) begin
          state_q   <= S_SCAN;
          msg_valid <= 1'b0;
          ch_q      <= ch_q + 4'd1;
          rep_q     <= rep_q + 4'd1;
        end
        S_END: if (msg_ready) begin
          state_q   <= S_IDLE;
          msg_valid <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_colour_bbox_tracker.sv
// Scoreboard bench: a frame model pushes expected report words, a negedge monitor pops and compares.
module tb_multi_colour_bbox_tracker;

  localparam int unsigned W = 16, H = 8, N = 4, CW = 4, XW = 11, NW = 6;
  localparam int unsigned INTV = 3, MINP = 2;
  localparam int unsigned SAT = (1 << NW) - 1;

  logic          clk, reset;
  logic          pix_valid, pix_sop, pix_eop, pix_video;
  logic [CW-1:0] pix_class;
  logic [31:0]   msg_data;
  logic          msg_valid, msg_ready, busy, frame_done, msg_dropped;

  multi_colour_bbox_tracker #(
    .IMAGE_W(W), .IMAGE_H(H), .N_COLOURS(N), .CLASS_W(CW), .COORD_W(XW),
    .CNT_W(NW), .MSG_INTERVAL(INTV), .MIN_PIXELS(MINP)
  ) dut (
    .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_sop(pix_sop),
    .pix_eop(pix_eop), .pix_video(pix_video), .pix_class(pix_class),
    .msg_data(msg_data), .msg_valid(msg_valid), .msg_ready(msg_ready),
    .busy(busy), .frame_done(frame_done), .msg_dropped(msg_dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned vectors = 0, miscompares = 0;
  logic [31:0] exp_q[$];
  int          rdy_mode = 0, rdy_credit = 0;
  int unsigned fd_cnt = 0, drop_cnt = 0, exp_fd = 0, exp_drop = 0;
  int unsigned m_fc = 0;
  logic [15:0] m_seq = '0;
  logic        stall_prev = 1'b0;
  logic [31:0] held = '0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] cls_of(input int pat, input int x, input int y);
    logic [3:0] c;
    c = '0;
    case (pat)
      0: begin
        if ((x == 10 && y == 3) || (x == 12 && y == 5)) c = 4'd1;
        else if (x == 2 && y == 1) c = 4'd2;
        else if ((x == 4 && y == 6) || (x == 15 && y == 0) || (x == 0 && y == 7)) c = 4'd3;
        else if (x == 5 && y == 5) c = 4'd7;
        else if (x == 6 && y == 6) c = 4'd15;
      end
      1: if (x == y) c = 4'd4; else if (x == 15) c = 4'd1;
      2: if (y == 2) c = 4'd2; else if ((x == 3 && y == 4) || (x == 9 && y == 6)) c = 4'd4;
      3: c = 4'd2;
      4: if (x == 1 && y == 1) c = 4'd1; else if (x == 3 && y == 3) c = 4'd2;
      default: c = 4'd1;
    endcase
    return c;
  endfunction

  task automatic model_frame_end(input int pat);
    int unsigned cnt[N], xmn[N], ymn[N], xmx[N], ymx[N];
    int unsigned rep, s;
    logic [3:0]  c;
    for (int k = 0; k < N; k++) begin
      cnt[k] = 0; xmn[k] = W - 1; ymn[k] = H - 1; xmx[k] = 0; ymx[k] = 0;
    end
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        c = cls_of(pat, x, y);
        if (c >= 1 && c <= N) begin
          cnt[c-1]++;
          if (x < xmn[c-1]) xmn[c-1] = x;
          if (y < ymn[c-1]) ymn[c-1] = y;
          if (x > xmx[c-1]) xmx[c-1] = x;
          if (y > ymx[c-1]) ymx[c-1] = y;
        end
      end
    if (m_fc != 0) begin
      m_fc--;
      return;
    end
    m_fc = INTV - 1;
    if (exp_q.size() != 0) begin
      exp_drop++;
      return;
    end
    m_seq++;
    rep = 0;
    for (int k = 0; k < N; k++) begin
      s = (cnt[k] > SAT) ? SAT : cnt[k];
      if (s >= MINP) begin
        exp_q.push_back({8'h42, 4'h0, 4'(k), m_seq});
        exp_q.push_back({16'(xmn[k]), 16'(ymn[k])});
        exp_q.push_back({16'(xmx[k]), 16'(ymx[k])});
        exp_q.push_back(32'(s));
        rep++;
      end
    end
    exp_q.push_back({8'h45, 8'h4F, 8'h46, 4'h0, 4'(rep)});
  endtask

  task automatic send_frame(input int pat, input bit video);
    logic last;
    pix_valid = 1'b1; pix_sop = 1'b1; pix_eop = 1'b0; pix_video = video; pix_class = '0;
    tick();
    pix_sop = 1'b0; pix_video = 1'b0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        last = (x == W - 1) && (y == H - 1);
        if ($urandom_range(0, 5) == 0) begin
          pix_valid = 1'b0; pix_eop = 1'b1; pix_class = 4'd1;
          tick();
        end
        pix_valid = 1'b1; pix_eop = last; pix_class = cls_of(pat, x, y);
        if (last && video) begin
          model_frame_end(pat);
          exp_fd++;
        end
        tick();
      end
    pix_valid = 1'b0; pix_eop = 1'b0; pix_class = '0;
    tick();
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 3000; i++) begin
      if (exp_q.size() == 0 && !busy) break;
      tick();
    end
    check_val("drain_queue", exp_q.size(), 0);
    check_val("drain_busy", busy, 1'b0);
  endtask

  initial begin
    msg_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0: msg_ready = 1'b1;
        1: msg_ready = ~msg_ready;
        2: msg_ready = 1'b0;
        default: begin
          msg_ready = (rdy_credit > 0);
          if (rdy_credit > 0) rdy_credit--;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (frame_done) fd_cnt++;
    if (msg_dropped) drop_cnt++;
    if (msg_valid && stall_prev) check_val("stall_hold", msg_data, held);
    if (msg_valid && msg_ready) begin
      check_val("word_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check_val("msg_word", msg_data, exp_q.pop_front());
    end
    stall_prev = msg_valid && !msg_ready;
    held = msg_data;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; pix_valid = 1'b0; pix_sop = 1'b0; pix_eop = 1'b0;
    pix_video = 1'b0; pix_class = '0;
    repeat (3) tick();
    check_val("rst_valid", msg_valid, 1'b0);
    check_val("rst_busy", busy, 1'b0);
    reset = 1'b0;
    tick();
    check_val("rst_data", msg_data, 32'h0);
    check_val("rst_fdone", frame_done, 1'b0);
    check_val("rst_drop", msg_dropped, 1'b0);

    send_frame(0, 1'b1);                 // report, stall-free
    wait_drain();
    send_frame(1, 1'b1);
    send_frame(5, 1'b0);                 // control packet full of class 1
    send_frame(1, 1'b1);
    rdy_mode = 1;
    send_frame(2, 1'b1);                 // report under toggling ready
    send_frame(3, 1'b1);
    send_frame(3, 1'b1);
    send_frame(3, 1'b1);                 // report, saturated count
    wait_drain();

    rdy_mode = 2;
    send_frame(0, 1'b1);
    send_frame(0, 1'b1);
    send_frame(1, 1'b1);                 // report starts, stalls
    send_frame(2, 1'b1);
    send_frame(2, 1'b1);
    send_frame(0, 1'b1);                 // report while busy: dropped
    check_val("drop_seen", drop_cnt, 1);
    rdy_mode = 0;
    wait_drain();

    send_frame(0, 1'b1);
    send_frame(0, 1'b1);
    send_frame(4, 1'b1);                 // report with every channel below threshold
    wait_drain();

    rdy_mode = 2;
    send_frame(1, 1'b1);
    send_frame(1, 1'b1);
    send_frame(0, 1'b1);                 // report, then stop inside BR
    for (int i = 0; i < 50; i++) begin
      if (msg_valid) break;
      tick();
    end
    check_val("hdr_valid", msg_valid, 1'b1);
    rdy_credit = 2;
    rdy_mode = 3;
    repeat (5) tick();
    check_val("br_valid", msg_valid, 1'b1);
    check_val("br_word", msg_data, 32'h000C_0005);
    @(posedge clk);
    #3 reset = 1'b1;
    exp_q.delete();
    m_fc = 0;
    m_seq = '0;
    rdy_mode = 0;
    #1;
    check_val("async_rst_valid", msg_valid, 1'b0);
    check_val("async_rst_busy", busy, 1'b0);
    repeat (2) tick();
    reset = 1'b0;
    tick();
    check_val("post_rst_busy", busy, 1'b0);
    check_val("post_rst_valid", msg_valid, 1'b0);

    send_frame(0, 1'b1);                 // header must carry sequence 1 again
    wait_drain();

    check_val("frame_done_count", fd_cnt, exp_fd);
    check_val("dropped_count", drop_cnt, exp_drop);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
